// File: rtl/iob_mem_responder.sv
// iob_mem_responder: IOb slave memory with read latency, outstanding-read cap, optional LFSR backpressure (IOB_MEM_RESPONDER_BACKPRESSURE_EN)
module iob_mem_responder #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 12,
  parameter int LATENCY   = 4,
  parameter int MAX_OUTST = 4
) (
  input  logic                clk_i,
  input  logic                arst_n_i,
  input  logic                cke_i,
  input  logic                iob_valid_i,
  input  logic [ADDR_W-1:0]   iob_addr_i,
  input  logic [DATA_W-1:0]   iob_wdata_i,
  input  logic [DATA_W/8-1:0] iob_wstrb_i,
  output logic [DATA_W-1:0]   iob_rdata_o,
  output logic                iob_rvalid_o,
  output logic                iob_ready_o
);
  localparam int CNT_W = $clog2(MAX_OUTST + 1);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] dat [LATENCY];
  logic [LATENCY-1:0] vld;
  logic [CNT_W-1:0] out_cnt;
  logic bp_ok, acc, rd_acc, wr_acc;
`ifdef IOB_MEM_RESPONDER_BACKPRESSURE_EN
  logic [15:0] lfsr;
  // free-running backpressure source, advances only on enabled cycles
  always_ff @(posedge clk_i or negedge arst_n_i)
    if (!arst_n_i) lfsr <= 16'hACE1;
    else if (cke_i) lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  assign bp_ok = ~(lfsr[1] & lfsr[0]);
`else
  assign bp_ok = 1'b1;
`endif
  assign iob_ready_o  = cke_i & (out_cnt < CNT_W'(MAX_OUTST)) & bp_ok;
  assign acc          = iob_valid_i & iob_ready_o;
  assign rd_acc       = acc & ~|iob_wstrb_i;
  assign wr_acc       = acc & |iob_wstrb_i;
  assign iob_rvalid_o = cke_i & vld[LATENCY-1];
  assign iob_rdata_o  = iob_rvalid_o ? dat[LATENCY-1] : '0;
  // byte-masked write into storage; contents survive reset
  always_ff @(posedge clk_i)
    for (int i = 0; i < DATA_W / 8; i++)
      if (wr_acc && iob_wstrb_i[i]) mem[iob_addr_i][i*8 +: 8] <= iob_wdata_i[i*8 +: 8];
  // read data pipeline; payload is only meaningful where the matching valid bit is set
  always_ff @(posedge clk_i)
    if (cke_i) begin
      dat[0] <= mem[iob_addr_i];
      for (int i = 1; i < LATENCY; i++) dat[i] <= dat[i-1];
    end
  // pipeline valid bits and outstanding-read counter
  always_ff @(posedge clk_i or negedge arst_n_i)
    if (!arst_n_i) begin
      vld     <= '0;
      out_cnt <= '0;
    end else if (cke_i) begin
      vld[0] <= rd_acc;
      for (int i = 1; i < LATENCY; i++) vld[i] <= vld[i-1];
      out_cnt <= out_cnt + CNT_W'(rd_acc) - CNT_W'(iob_rvalid_o);
    end
endmodule
